range_max_scan: RTL and testbench

// - Downstream consumer of the Collatz range engine (the RAM_WORDS-entry count store).
// - Launches one range run from a base value and waits for its done pulse.
// - Sweeps the count RAM through the engine's read-address path and reports the largest count.
// - Reports the starting n that produced that count over a valid/ready result port.
// - Sits between the range engine and the board-level display/readout logic.

---
 rtl/range_pkg.sv | 19 +
 rtl/range_max_track.sv | 52 +++++
 rtl/range_max_scan.sv | 133 +++++++++++++
 tb/tb_range_max_scan.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/range_pkg.sv
// Shared types and widths for the range max scanner.
// Optional RANGE_MAX_SCAN_SUM_EN adds a running total of the counts.
package range_pkg;

  localparam int RAM_WORDS     = 16;
  localparam int RAM_ADDR_BITS = 4;
  localparam int COUNT_W       = 16;
  localparam int SUM_W         = COUNT_W + RAM_ADDR_BITS;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    SCAN,
    DRAIN,
    RESULT
  } scan_state_t;

endpackage

// File: rtl/range_max_track.sv
// Running maximum with its index; strict-greater so ties keep the lowest index.
import range_pkg::*;

module range_max_track #(
  parameter int W  = COUNT_W,
  parameter int IW = RAM_ADDR_BITS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          sample_i,
  input  logic [W-1:0]  value_i,
  input  logic [IW-1:0] index_i,
  output logic [W-1:0]  max_o,
  output logic [IW-1:0] idx_o
);

  logic [W-1:0]  max_q, max_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          first_q, first_d;

  always_comb begin
    max_d   = max_q;
    idx_d   = idx_q;
    first_d = first_q;
    if (clear_i) begin
      max_d   = '0;
      idx_d   = '0;
      first_d = 1'b1;
    end else if (sample_i && (first_q || value_i > max_q)) begin
      max_d   = value_i;
      idx_d   = index_i;
      first_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q   <= '0;
      idx_q   <= '0;
      first_q <= 1'b0;
    end else begin
      max_q   <= max_d;
      idx_q   <= idx_d;
      first_q <= first_d;
    end
  end

  assign max_o = max_q;
  assign idx_o = idx_q;

endmodule

// File: rtl/range_max_scan.sv
// Launches a range run, scans its count RAM and reports the largest count.
// Define RANGE_MAX_SCAN_SUM_EN to add the sum_count output.
import range_pkg::*;

module range_max_scan #(
  parameter int RAM_WORDS     = range_pkg::RAM_WORDS,
  parameter int RAM_ADDR_BITS = range_pkg::RAM_ADDR_BITS,
  parameter int COUNT_W       = range_pkg::COUNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  logic [31:0]        base,
  output logic               req_ready,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [COUNT_W-1:0] max_count,
  output logic [31:0]        max_n,
`ifdef RANGE_MAX_SCAN_SUM_EN
  output logic [COUNT_W+RAM_ADDR_BITS-1:0] sum_count,
`endif
  output logic               r_go,
  output logic [31:0]        r_start,
  input  logic               r_done,
  input  logic [COUNT_W-1:0] r_count
);

  localparam logic [RAM_ADDR_BITS-1:0] LAST =
    RAM_ADDR_BITS'(RAM_WORDS - 1);

  scan_state_t              state_q, state_d;
  logic [31:0]              base_q, base_d;
  logic [RAM_ADDR_BITS-1:0] idx_q, idx_d;
  logic [RAM_ADDR_BITS-1:0] max_idx;
  logic                     accept;
  logic                     sample;

  assign accept = (state_q == IDLE) && req;
  // Registered read: data seen now belongs to the previous address.
  assign sample = ((state_q == SCAN) && (idx_q != '0))
                || (state_q == DRAIN);

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    idx_d     = idx_q;
    req_ready = 1'b0;
    res_valid = 1'b0;
    r_go      = 1'b0;
    r_start   = '0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req) begin
          base_d  = base;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        r_go    = 1'b1;
        r_start = base_q;
        state_d = WAIT;
      end
      WAIT: begin
        r_start = base_q;
        if (r_done) begin
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        r_start = {{(32-RAM_ADDR_BITS){1'b0}}, idx_q};
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) state_d = DRAIN;
      end
      DRAIN: state_d = RESULT;
      RESULT: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
    end
  end

  range_max_track #(
    .W  (COUNT_W),
    .IW (RAM_ADDR_BITS)
  ) u_track (
    .clk      (clk),
    .rst      (reset),
    .clear_i  (accept),
    .sample_i (sample),
    .value_i  (r_count),
    .index_i  (idx_q - 1'b1),
    .max_o    (max_count),
    .idx_o    (max_idx)
  );

  assign max_n = base_q
               + {{(32-RAM_ADDR_BITS){1'b0}}, max_idx};

`ifdef RANGE_MAX_SCAN_SUM_EN
  logic [COUNT_W+RAM_ADDR_BITS-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (accept)
      sum_d = '0;
    else if (sample)
      sum_d = sum_q + {{RAM_ADDR_BITS{1'b0}}, r_count};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sum_q <= '0;
    else       sum_q <= sum_d;
  end

  assign sum_count = sum_q;
`endif

endmodule

// File: tb/tb_range_max_scan.sv
// Randomized bench for range_max_scan against a behavioural engine
// and a table-level reference model.
module tb_range_max_scan;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic [31:0] base = '0;
  logic        req_ready;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] max_count;
  logic [31:0] max_n;
`ifdef RANGE_MAX_SCAN_SUM_EN
  logic [19:0] sum_count;
`endif
  logic        r_go;
  logic [31:0] r_start;
  logic        r_done;
  logic [15:0] r_count = '0;

  logic        eng_done = 1'b0;
  logic        spur = 1'b0;
  logic [3:0]  eng_cnt = '0;
  logic [15:0] tbl [16];

  int total = 0;
  int bad = 0;

  assign r_done = eng_done | spur;

  always #5 clk = ~clk;

  range_max_scan dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .base      (base),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .max_count (max_count),
    .max_n     (max_n),
`ifdef RANGE_MAX_SCAN_SUM_EN
    .sum_count (sum_count),
`endif
    .r_go      (r_go),
    .r_start   (r_start),
    .r_done    (r_done),
    .r_count   (r_count)
  );

  // Engine model: no reset, programmable latency, registered read.
  always @(posedge clk) begin
    r_count  <= tbl[r_start[3:0]];
    eng_done <= 1'b0;
    if (r_go) begin
      eng_cnt <= 4'($urandom_range(1, 6));
    end else if (eng_cnt != 0) begin
      eng_cnt <= eng_cnt - 1'b1;
      if (eng_cnt == 1) eng_done <= 1'b1;
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [31:0] b,
                       output logic [15:0] mc,
                       output logic [31:0] mn,
                       output logic [19:0] sm);
    int best;
    best = 0;
    sm = '0;
    for (int i = 0; i < 16; i++) begin
      sm = sm + 20'(tbl[i]);
      if (tbl[i] > tbl[best]) best = i;
    end
    mc = tbl[best];
    mn = b + 32'(best);
  endtask

  task automatic run(input logic [31:0] b,
                     input bit stall,
                     input bit spur_scan);
    logic [15:0] mc;
    logic [31:0] mn;
    logic [19:0] sm;
    int after;
    bit got;
    model(b, mc, mn, sm);
    chk("req_ready_idle", req_ready, 1);
    req  = 1'b1;
    base = b;
    @(negedge clk);
    req  = 1'b0;
    base = $urandom;
    chk("r_go_launch", r_go, 1);
    chk("r_start_launch", r_start, b);
    after = -1;
    got = 0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (res_valid) got = 1;
      if (r_done && after < 0) after = 0;
      else if (after >= 0) after++;
      spur = spur_scan && (after == 4);
    end
    spur = 1'b0;
    chk("res_timeout", got, 1);
    chk("max_count", max_count, mc);
    chk("max_n", max_n, mn);
`ifdef RANGE_MAX_SCAN_SUM_EN
    chk("sum_count", sum_count, sm);
`endif
    if (stall) begin
      req = 1'b1;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        chk("stall_valid", res_valid, 1);
        chk("stall_ready", req_ready, 0);
        chk("stall_max", max_count, mc);
        chk("stall_n", max_n, mn);
      end
      req = 1'b0;
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("valid_drop", res_valid, 0);
    chk("idle_ready", req_ready, 1);
    chk("hold_max", max_count, mc);
    chk("hold_n", max_n, mn);
  endtask

  task automatic fill(input int mode, input logic [15:0] v);
    for (int i = 0; i < 16; i++) begin
      unique case (mode)
        0: tbl[i] = v;
        1: tbl[i] = 16'(i + 1);
        2: tbl[i] = 16'($urandom_range(0, 7));
        default: tbl[i] = 16'($urandom);
      endcase
    end
  endtask

  initial begin
    fill(0, 16'd0);
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_max_count", max_count, 0);
    chk("rst_max_n", max_n, 0);
    chk("rst_r_go", r_go, 0);
    chk("rst_r_start", r_start, 0);
`ifdef RANGE_MAX_SCAN_SUM_EN
    chk("rst_sum", sum_count, 0);
`endif
    reset = 1'b0;
    @(negedge clk);

    fill(0, 16'd10);
    tbl[5] = 16'd200;
    tbl[9] = 16'd200;
    run(32'd100, 0, 0);
    chk("tie_max", max_count, 200);
    chk("tie_n", max_n, 105);

    fill(1, 16'd0);
    run(32'hFFFF_FFF8, 0, 0);
    chk("wrap_n", max_n, 32'h0000_0007);

    fill(0, 16'd0);
    run(32'h1234_5678, 0, 0);
    chk("zero_n", max_n, 32'h1234_5678);

    fill(0, 16'hFFFF);
    run(32'd7, 0, 0);
`ifdef RANGE_MAX_SCAN_SUM_EN
    chk("full_sum", sum_count, 20'hFFFF0);
`endif

    fill(3, 16'd0);
    run($urandom, 1, 0);

    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    chk("spur_idle_ready", req_ready, 1);
    chk("spur_idle_valid", res_valid, 0);
    chk("spur_idle_go", r_go, 0);

    fill(2, 16'd0);
    run($urandom, 0, 1);

    req  = 1'b1;
    base = 32'd55;
    @(negedge clk);
    req = 1'b0;
    for (int c = 0; c < 50 && !r_done; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_valid", res_valid, 0);
    chk("rst_mid_go", r_go, 0);
    chk("rst_mid_ready", req_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    fill(3, 16'd0);
    run(32'd900, 0, 0);

    for (int t = 0; t < 10; t++) begin
      fill(t % 2 == 0 ? 2 : 3, 16'd0);
      run($urandom, t == 3, t == 6);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
